// File: rtl/morse_tone_sequencer.sv
// Plays one Morse character on a piezo buzzer: dot/dash tones with standard
// element, inter-element and trailing character gaps, all timed from clk.
module morse_tone_sequencer #(
    parameter int UNIT_CYC  = 200000,
    parameter int TONE_HALF = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [4:0] morse_code,
    input  logic [2:0] morse_len,
    output logic       buzzer_out,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);

    // Duration counter must reach 3*UNIT_CYC-1 (dash and tail) without wrapping.
    localparam int DUR_W  = $clog2(3 * UNIT_CYC);
    localparam int HALF_W = $clog2(TONE_HALF + 1);

    localparam logic [DUR_W-1:0]  UNIT_LAST = DUR_W'(UNIT_CYC - 1);
    localparam logic [DUR_W-1:0]  LONG_LAST = DUR_W'(3 * UNIT_CYC - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(TONE_HALF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2,
        TAIL = 2'd3
    } state_t;

    state_t            state_q, state_n;
    logic [DUR_W-1:0]  dur_q, dur_n;
    logic [HALF_W-1:0] half_q, half_n;
    logic [4:0]        code_q, code_n;
    logic [2:0]        len_q, len_n;
    logic [2:0]        idx_q, idx_n;
    logic              buzz_n, busy_n, done_n;

    logic [2:0] bit_sel;
    logic [4:0] code_shift;
    logic       cur_dash;
    logic       last_elem;

    // Element k is code[len-1-k]: the first element is the most significant used bit.
    assign bit_sel    = len_q - 3'd1 - idx_q;
    assign code_shift = code_q >> bit_sel;
    assign cur_dash   = code_shift[0];
    assign last_elem  = (idx_q == (len_q - 3'd1));
    assign state_dbg  = state_q;

    always_comb begin
        state_n = state_q;
        dur_n   = dur_q;
        idx_n   = idx_q;
        code_n  = code_q;
        len_n   = len_q;
        done_n  = 1'b0;
        half_n  = '0;
        buzz_n  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (morse_len != 3'd0) && (morse_len <= 3'd5)) begin
                    state_n = TONE;
                    code_n  = morse_code;
                    len_n   = morse_len;
                    idx_n   = 3'd0;
                    dur_n   = '0;
                end
            end
            TONE: begin
                if (dur_q == (cur_dash ? LONG_LAST : UNIT_LAST)) begin
                    dur_n   = '0;
                    state_n = last_elem ? TAIL : GAP;
                end else begin
                    dur_n = dur_q + 1'b1;
                end
            end
            GAP: begin
                if (dur_q == UNIT_LAST) begin
                    dur_n   = '0;
                    idx_n   = idx_q + 3'd1;
                    state_n = TONE;
                end else begin
                    dur_n = dur_q + 1'b1;
                end
            end
            TAIL: begin
                if (dur_q == LONG_LAST) begin
                    dur_n   = '0;
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    dur_n = dur_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_n = IDLE;
            dur_n   = '0;
            done_n  = 1'b0;
        end

        // Square wave restarts high on every tone entry so each element sounds identically.
        if (state_n == TONE) begin
            if (state_q != TONE) begin
                half_n = '0;
                buzz_n = 1'b1;
            end else if (half_q == HALF_LAST) begin
                half_n = '0;
                buzz_n = ~buzzer_out;
            end else begin
                half_n = half_q + 1'b1;
                buzz_n = buzzer_out;
            end
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dur_q      <= '0;
            half_q     <= '0;
            code_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            buzzer_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_n;
            dur_q      <= dur_n;
            half_q     <= half_n;
            code_q     <= code_n;
            len_q      <= len_n;
            idx_q      <= idx_n;
            buzzer_out <= buzz_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_morse_tone_sequencer.sv
// Bench for morse_tone_sequencer: a per-cycle scoreboard of {busy, buzzer_out, done}
// filled from a timing model whenever a character is started.
module tb_morse_tone_sequencer;

    localparam int U  = 10;
    localparam int TH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [4:0] morse_code;
    logic [2:0] morse_len;
    logic       buzzer_out;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q[$];

    morse_tone_sequencer #(
        .UNIT_CYC (U),
        .TONE_HALF(TH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .morse_code(morse_code),
        .morse_len (morse_len),
        .buzzer_out(buzzer_out),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Clock and sampling: inputs change at negedge+1, outputs are checked at negedge.
    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({busy, buzzer_out, done} !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t busy/buzz/done got=%b expected=%b",
                         $time, {busy, buzzer_out, done}, e);
            end
        end
    end

    // Expected per-cycle outputs from the cycle after start through the done cycle.
    task automatic push_model(input logic [4:0] c, input logic [2:0] l, input int limit);
        logic [2:0] tmp[$];
        int n;
        for (int k = 0; k < int'(l); k++) begin
            n = c[int'(l) - 1 - k] ? 3 * U : U;
            for (int i = 0; i < n; i++)
                tmp.push_back({1'b1, ((i / TH) % 2) == 0, 1'b0});
            if (k < int'(l) - 1)
                for (int i = 0; i < U; i++) tmp.push_back(3'b100);
        end
        for (int i = 0; i < 3 * U; i++) tmp.push_back(3'b100);
        tmp.push_back(3'b001);
        for (int i = 0; i < tmp.size() && i < limit; i++) exp_q.push_back(tmp[i]);
    endtask

    task automatic start_char(input logic [4:0] c, input logic [2:0] l, input int limit);
        start      = 1'b1;
        morse_code = c;
        morse_len  = l;
        push_model(c, l, limit);
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    // Returns in the second half of the cycle whose sample emptied the queue.
    task automatic wait_drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(3'b000);
        wait_drain();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; morse_code = '0; morse_len = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, buzzer_out, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected=000", {busy, buzzer_out, done});
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d expected=0", state_dbg);
        end
        #1 rst = 1'b0;
        idle_cycles(3);
    endtask

    task automatic test_reset_mid_tone();
        start_char(5'b00000, 3'd1, 1);
        exp_q.delete();
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, buzzer_out, done} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset got=%b expected=000", {busy, buzzer_out, done});
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL async_reset_state got=%0d expected=0", state_dbg);
        end
        @(negedge clk); #1;
        rst = 1'b0;
        start_char(5'b00000, 3'd1, 1 << 20);
        wait_drain();
    endtask

    task automatic test_char_e();
        start_char(5'b00000, 3'd1, 1 << 20);
        wait_drain();
        idle_cycles(2);
    endtask

    task automatic test_char_a();
        start_char(5'b00001, 3'd2, 1 << 20);
        wait_drain();
        idle_cycles(2);
    endtask

    task automatic test_invalid_start();
        start = 1'b1; morse_code = 5'b10101; morse_len = 3'd0;
        exp_q.push_back(3'b000);
        @(negedge clk); #1;
        morse_len = 3'd6;
        exp_q.push_back(3'b000);
        @(negedge clk); #1;
        morse_len = 3'd7;
        exp_q.push_back(3'b000);
        @(negedge clk); #1;
        start = 1'b0;
        idle_cycles(4);
    endtask

    task automatic test_restart_ignored();
        start_char(5'b00001, 3'd2, 1 << 20);
        repeat (14) @(negedge clk);
        #1;
        start = 1'b1; morse_code = 5'b11111; morse_len = 3'd5;
        @(negedge clk); #1;
        start = 1'b0;
        wait_drain();
        idle_cycles(2);
    endtask

    task automatic test_abort();
        start_char(5'b00001, 3'd2, 25);
        wait_drain();
        abort = 1'b1;
        exp_q.push_back(3'b000);
        @(negedge clk); #1;
        abort = 1'b0;
        start_char(5'b00000, 3'd1, 1 << 20);
        wait_drain();
        abort = 1'b1;
        idle_cycles(3);
        abort = 1'b0;
    endtask

    task automatic test_back_to_back();
        start_char(5'b00001, 3'd1, 1 << 20);
        wait_drain();
        start_char(5'b00000, 3'd1, 1 << 20);
        wait_drain();
        idle_cycles(2);
    endtask

    task automatic test_random();
        logic [4:0] c;
        logic [2:0] l;
        for (int i = 0; i < 4; i++) begin
            c = 5'($urandom_range(0, 31));
            l = 3'($urandom_range(1, 5));
            start_char(c, l, 1 << 20);
            wait_drain();
        end
        idle_cycles(2);
    endtask

    initial begin
        test_reset();
        test_reset_mid_tone();
        test_char_e();
        test_char_a();
        test_invalid_start();
        test_restart_ignored();
        test_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
